// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Direction type, direction constants and helpers shared by the
//            direction controller, movement engine and renderer.
// Revision : 1.0
// ============================================================================
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   // Opposite directions differ only in bit 0.
   function automatic dir_t opposite(input dir_t d);
      return d ^ 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : Rising-edge detector for the four debounced direction buttons.
// Revision : 1.0
// ============================================================================
module btn_edge (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   output logic [3:0] press
);

   logic [3:0] r_prev;

   // Reset to ones so a button held through reset release never fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 4'hF;
      end else begin
         r_prev <= btn;
      end
   end

   assign press = btn & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_ctrl
// Purpose  : Turns button presses into queued turns, applying one per tick.
// Revision : 1.0
// ============================================================================
module snake_dir_ctrl
   import snake_pkg::*;
#(
   parameter int         QDEPTH   = 2,
   parameter logic [1:0] INIT_DIR = 2'd3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_up,
   input  logic                        btn_down,
   input  logic                        btn_left,
   input  logic                        btn_right,
   input  logic                        tick,
   output logic [1:0]                  dir,
   output logic                        turned,
   output logic [$clog2(QDEPTH+1)-1:0] q_level,
   output logic                        drop
);

   localparam int c_ptr_w = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int c_lvl_w = $clog2(QDEPTH + 1);
   localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(QDEPTH - 1);
   localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(QDEPTH);

   if (QDEPTH < 1 || QDEPTH > 4) begin : g_qdepth_check
      $error("snake_dir_ctrl: QDEPTH must be in 1..4");
   end

   logic [3:0]         w_btn;
   logic [3:0]         w_press;
   dir_t               r_mem [QDEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] w_tail_ptr;
   logic [c_lvl_w-1:0] r_level;
   dir_t               r_dir;
   logic               r_turned;
   logic               r_drop;
   logic               w_cand_vld;
   dir_t               w_cand;
   dir_t               w_ref;
   logic               w_accept;
   logic               w_full;
   logic               w_push;
   logic               w_pop;

   function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last) ? '0 : p + 1'b1;
   endfunction

   // Bit index equals direction encoding, so bit 0 (UP) has top priority.
   assign w_btn = {btn_right, btn_left, btn_down, btn_up};

   btn_edge u_btn_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (w_btn),
      .press (w_press)
   );

   always_comb begin
      w_cand_vld = |w_press;
      w_cand     = DIR_RIGHT;
      if (w_press[0]) begin
         w_cand = DIR_UP;
      end else if (w_press[1]) begin
         w_cand = DIR_DOWN;
      end else if (w_press[2]) begin
         w_cand = DIR_LEFT;
      end
   end

   // New turns are judged against the last queued turn, not the live heading.
   assign w_tail_ptr = (r_wr_ptr == '0) ? c_last : r_wr_ptr - 1'b1;
   assign w_ref      = (r_level != '0) ? r_mem[w_tail_ptr] : r_dir;
   assign w_accept   = w_cand_vld && (w_cand != w_ref) && (w_cand != opposite(w_ref));
   assign w_full     = (r_level == c_full);
   assign w_push     = w_accept && !w_full;
   assign w_pop      = tick && (r_level != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_dir    <= INIT_DIR;
         r_turned <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_turned <= w_pop;
         r_drop   <= w_accept && w_full;
         if (w_pop) begin
            r_dir    <= r_mem[r_rd_ptr];
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: entries are only read below the fill level.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_cand;
      end
   end

   assign dir     = r_dir;
   assign turned  = r_turned;
   assign q_level = r_level;
   assign drop    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_dir_ctrl
// Purpose  : Scoreboard bench for snake_dir_ctrl against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_snake_dir_ctrl;

   localparam int         QDEPTH   = 2;
   localparam logic [1:0] INIT_DIR = 2'd3;
   localparam int         LW       = $clog2(QDEPTH + 1);

   typedef struct packed {
      logic [1:0]    dir;
      logic          turned;
      logic [LW-1:0] lvl;
      logic          drop;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          btn_up, btn_down, btn_left, btn_right, tick;
   logic [1:0]    dir;
   logic          turned;
   logic [LW-1:0] q_level;
   logic          drop;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t       exp_q[$];
   logic [1:0] m_q[$];
   logic [3:0] m_prev = 4'hF;
   logic [1:0] m_dir  = INIT_DIR;

   snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(INIT_DIR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .tick      (tick),
      .dir       (dir),
      .turned    (turned),
      .q_level   (q_level),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: a queue of pending directions plus the current heading.
   task automatic model_step(input logic [3:0] b, input logic t, input logic r);
      exp_t       e;
      logic [3:0] pr;
      logic [1:0] c, rf;
      logic       found, acc, full;
      e = '0;
      if (!r) begin
         m_prev = 4'hF;
         m_q.delete();
         m_dir = INIT_DIR;
      end else begin
         pr     = b & ~m_prev;
         m_prev = b;
         found  = 1'b0;
         c      = 2'd0;
         for (int i = 0; i < 4; i++) begin
            if (!found && pr[i]) begin
               found = 1'b1;
               c     = 2'(i);
            end
         end
         rf   = (m_q.size() > 0) ? m_q[$] : m_dir;
         acc  = found && (c != rf) && (c != (rf ^ 2'd1));
         full = (m_q.size() == QDEPTH);
         e.drop = acc && full;
         if (t && m_q.size() > 0) begin
            m_dir    = m_q.pop_front();
            e.turned = 1'b1;
         end
         if (acc && !full) m_q.push_back(c);
      end
      e.dir = m_dir;
      e.lvl = LW'(m_q.size());
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [3:0] b, input logic t, input logic r);
      @(negedge clk);
      {btn_right, btn_left, btn_down, btn_up} = b;
      tick  = t;
      rst_n = r;
      model_step(b, t, r);
      if (!r) begin
         #1;
         check("async_rst_dir", dir, INIT_DIR);
         check("async_rst_lvl", q_level, 0);
         check("async_rst_turned", turned, 0);
      end
   endtask

   task automatic idle(input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0, 1'b1);
   endtask

   // Monitor: compares every registered output once per clock.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("dir", dir, e.dir);
         check("turned", turned, e.turned);
         check("q_level", q_level, e.lvl);
         check("drop", drop, e.drop);
      end
   end

   initial begin
      logic [3:0] lvl;
      rst_n = 1'b0;
      {btn_right, btn_left, btn_down, btn_up} = 4'b1000;
      tick = 1'b0;

      // Right held through reset release, then tick: nothing should happen.
      step(4'b1000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      idle(4'b1000, 3);
      step(4'b1000, 1'b1, 1'b1);
      idle(4'b0000, 2);

      // Single UP press then tick.
      step(4'b0001, 1'b0, 1'b1);
      idle(4'b0000, 2);
      step(4'b0000, 1'b1, 1'b1);
      idle(4'b0000, 3);

      // Back to RIGHT; reversal and same-direction presses are rejected.
      step(4'b0000, 1'b0, 1'b0);
      idle(4'b0000, 1);
      step(4'b0100, 1'b0, 1'b1);
      idle(4'b0000, 1);
      step(4'b1000, 1'b0, 1'b1);
      idle(4'b0000, 1);
      step(4'b0000, 1'b1, 1'b1);
      idle(4'b0000, 2);

      // UP then LEFT queued, DOWN dropped when full, two ticks drain.
      step(4'b0001, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0010, 1'b0, 1'b1);
      idle(4'b0000, 2);
      step(4'b0000, 1'b1, 1'b1);
      idle(4'b0000, 1);
      step(4'b0000, 1'b1, 1'b1);
      idle(4'b0000, 2);

      // Simultaneous UP and LEFT from RIGHT: only UP survives.
      step(4'b0000, 1'b0, 1'b0);
      idle(4'b0000, 1);
      step(4'b0101, 1'b0, 1'b1);
      idle(4'b0000, 2);

      // Full FIFO with a tick popping in the same cycle still drops.
      step(4'b0000, 1'b0, 1'b0);
      idle(4'b0000, 1);
      step(4'b0001, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0010, 1'b1, 1'b1);
      idle(4'b0000, 2);

      // Two entries queued, reset during a tick discards them.
      step(4'b0000, 1'b0, 1'b0);
      idle(4'b0000, 1);
      step(4'b0001, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      step(4'b0000, 1'b1, 1'b0);
      idle(4'b0000, 1);
      step(4'b0000, 1'b1, 1'b1);
      step(4'b0000, 1'b1, 1'b1);
      idle(4'b0000, 2);

      // Randomised levels, ticks and occasional resets.
      lvl = 4'h0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 2) == 0) lvl = lvl ^ 4'($urandom_range(0, 15));
         step(lvl, ($urandom_range(0, 4) == 0), ($urandom_range(0, 249) != 0));
      end
      idle(4'b0000, 3);

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Turns the four debounced direction-button levels (outputs of the button debounce stage) into the snake's movement direction.
- Edge-detects each button and drops reversals and no-op turns.
- Queues accepted turns in a small FIFO so two quick presses within one game step both take effect.
- Applies one queued turn per game-step tick; the movement/collision engine consumes the result downstream.

Parameters:
- QDEPTH, 2, depth of the pending-turn FIFO; legal range 1..4.
- INIT_DIR, 2'd3, direction after reset (RIGHT).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_up  input  1  debounced UP level.
- btn_down  input  1  debounced DOWN level.
- btn_left  input  1  debounced LEFT level.
- btn_right  input  1  debounced RIGHT level.
- tick  input  1  one-cycle game-step strobe.
- dir  output  2  current movement direction.
- turned  output  1  one-cycle pulse: dir changed on this tick.
- q_level  output  $clog2(QDEPTH+1)  number of queued turns.
- drop  output  1  one-cycle pulse: an accepted press was discarded because the FIFO was full.

Behaviour:
- Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3. The opposite of d is d^1.
- Reset (async assert, rst_n=0):
  - dir=INIT_DIR; turned=0; drop=0; q_level=0; FIFO pointers cleared.
  - All four previous-level registers set to 1, so a button held through reset release does not fire.
- Edge detect, registered per button:
  - press_x = btn_x & ~prev_x; prev_x <= btn_x every cycle.
  - Press is usable in the same cycle it is detected (combinational off the register), so push happens at the edge after the button first reads high.
- Arbitration: if several presses occur in one cycle, take one only, priority UP > DOWN > LEFT > RIGHT. The others are lost.
- Reference direction ref: the FIFO tail entry if q_level>0, else dir. ref uses pre-pop contents.
- Accept rule:
  - Candidate c is accepted iff c != ref and c != ref^1.
  - Rejected candidates have no effect; no pulse.
- Push:
  - Accepted c is written to the tail if q_level < QDEPTH.
  - Otherwise drop=1 for one cycle and the FIFO is unchanged.
- Pop on tick=1 with q_level>0:
  - dir <= head entry; turned=1 in the next cycle (registered with dir).
  - The accept rule guarantees head != dir, so turned always accompanies a change.
- tick with an empty FIFO: dir holds; turned=0.
- Simultaneous push and pop in one cycle:
  - Both occur; q_level is unchanged.
  - Fullness for the push uses pre-pop q_level, so a full FIFO drops even when a tick pops in the same cycle.
  - The pushed entry is never the one popped that cycle. With an empty FIFO, the push lands and applies on the next tick (one step of latency, by design).
- Latency:
  - Press to dir change: first tick strictly after the push cycle, +1 clk for the register.
  - dir, turned and drop are all registered.
- Pointers wrap modulo QDEPTH. q_level saturates by construction and never exceeds QDEPTH.
- Reset mid-operation: pending turns are discarded immediately; dir returns to INIT_DIR.
- tick arriving while rst_n=0 is ignored.

Decomposition:
- Package snake_pkg holds:
  - dir_t (2-bit) and constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT.
  - Helper function opposite(d).
  - This package is shared with the movement engine and renderer.
- One sub-module: btn_edge (4-bit prev register plus rising-edge mask, reset-to-ones).
- The FIFO stays inline; it is too small to justify a separate module.

Test Plan:
- Reset release with btn_right held, then tick: dir=3, turned stays 0, q_level=0, no push.
- From dir=RIGHT, pulse btn_up, wait, tick: q_level goes 0→1→0; dir=0 one clk after tick; turned high exactly one cycle.
- From dir=RIGHT, press btn_left (reversal) then btn_right (same), then tick: no push, q_level=0, dir stays 3, turned=0.
- From dir=RIGHT, press up then left within one tick window, then tick, tick: q_level reaches 2; dir 3→0 on the first tick, 0→2 on the second. A third press (down) during the window raises drop=1 and leaves q_level=2.
- btn_up and btn_left rise in the same cycle from dir=RIGHT: only UP is queued (q_level=1); LEFT is lost.
- FIFO holding 2 entries, then assert rst_n=0 for 1 cycle during a tick: dir=INIT_DIR, q_level=0, turned=0; after release, ticks cause no change.
